// File: rtl/decode_queue_stage_if.sv
// Handshake and decoded-bundle bus for decode_queue_stage.
// master: the environment around the stage (fetch side drives in_*, execute
// side drives out_ready); slave: the decode stage itself.
interface decode_queue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rd_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] imm_value;
  logic [31:0] target_imm;
  logic        use_alu;
  logic        use_shifter;
  logic        use_comparator;
  logic        use_muldiv;
  logic        alu_src1;
  logic        alu_src2;
  logic [5:0]  alu_mode;
  logic [2:0]  shifter_mode;
  logic [2:0]  comparator_mode;
  logic [2:0]  muldiv_mode;
  logic        reg_write_en;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [1:0]  mem_access_mode;
  logic        mem_read_signed;
  logic        is_bj;
  logic        is_jalr;
  logic        illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rd_addr, rs1_addr, rs2_addr,
           imm_value, target_imm, use_alu, use_shifter, use_comparator,
           use_muldiv, alu_src1, alu_src2, alu_mode, shifter_mode,
           comparator_mode, muldiv_mode, reg_write_en, mem_read_en,
           mem_write_en, mem_access_mode, mem_read_signed, is_bj, is_jalr,
           illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rd_addr, rs1_addr, rs2_addr,
           imm_value, target_imm, use_alu, use_shifter, use_comparator,
           use_muldiv, alu_src1, alu_src2, alu_mode, shifter_mode,
           comparator_mode, muldiv_mode, reg_write_en, mem_read_en,
           mem_write_en, mem_access_mode, mem_read_signed, is_bj, is_jalr,
           illegal
  );
endinterface

// File: rtl/decode_queue_stage.sv
// RV32I(+M) decode stage: circular instruction queue feeding a registered
// decoded control bundle, with flush and illegal-encoding detection.
module decode_queue_stage #(
  parameter int QUEUE_DEPTH = 4,
  parameter bit ENABLE_M    = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  decode_queue_stage_if.slave              bus,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  localparam logic [5:0] ALU_ADD  = 6'b100101;
  localparam logic [5:0] ALU_SUB  = 6'b011011;
  localparam logic [5:0] ALU_OR   = 6'b111010;
  localparam logic [5:0] ALU_AND  = 6'b100010;
  localparam logic [5:0] ALU_XOR  = 6'b011010;
  localparam logic [5:0] ALU_PASS = 6'b101010;
  localparam logic [5:0] ALU_ZERO = 6'b000010;
  localparam logic [2:0] SH_LSR = 3'b001, SH_LSL = 3'b010, SH_ASR = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b000, CMP_LTU = 3'b001, CMP_GE = 3'b010;
  localparam logic [2:0] CMP_GEU = 3'b011, CMP_EQ = 3'b100, CMP_NEQ = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] target;
    logic        use_alu;
    logic        use_shifter;
    logic        use_comparator;
    logic        use_muldiv;
    logic        alu_src1;
    logic        alu_src2;
    logic [5:0]  alu_mode;
    logic [2:0]  shifter_mode;
    logic [2:0]  comparator_mode;
    logic [2:0]  muldiv_mode;
    logic        reg_write_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [1:0]  mem_access_mode;
    logic        mem_read_signed;
    logic        is_bj;
    logic        is_jalr;
    logic        illegal;
  } ctrl_t;

  // Idle bundle: nothing enabled, ALU forced to SET_ZERO, loads signed.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c                 = '0;
    c.alu_mode        = ALU_ZERO;
    c.mem_read_signed = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t       c;
    logic        ill;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {ins[31:12], 12'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    c     = ctrl_idle();
    c.rd  = ins[11:7];
    c.rs1 = ins[19:15];
    c.rs2 = ins[24:20];
    ill   = 1'b0;
    case (opc)
      7'b0110011: begin
        c.reg_write_en = 1'b1;
        if (ENABLE_M && f7 == 7'b0000001) begin
          c.use_muldiv  = 1'b1;
          c.muldiv_mode = f3;
        end else if (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          case (f3)
            3'b000: begin c.use_alu = 1'b1; c.alu_mode = f7[5] ? ALU_SUB : ALU_ADD; end
            3'b001: begin c.use_shifter = 1'b1; c.shifter_mode = SH_LSL; end
            3'b010: begin c.use_comparator = 1'b1; c.comparator_mode = CMP_LT; end
            3'b011: begin c.use_comparator = 1'b1; c.comparator_mode = CMP_LTU; end
            3'b100: begin c.use_alu = 1'b1; c.alu_mode = ALU_XOR; end
            3'b101: begin c.use_shifter = 1'b1; c.shifter_mode = f7[5] ? SH_ASR : SH_LSR; end
            3'b110: begin c.use_alu = 1'b1; c.alu_mode = ALU_OR; end
            default: begin c.use_alu = 1'b1; c.alu_mode = ALU_AND; end
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      7'b0010011: begin
        c.reg_write_en = 1'b1;
        c.alu_src2     = 1'b1;
        c.imm          = imm_i;
        case (f3)
          3'b000: begin c.use_alu = 1'b1; c.alu_mode = ALU_ADD; end
          3'b010: begin c.use_comparator = 1'b1; c.comparator_mode = CMP_LT; end
          3'b011: begin c.use_comparator = 1'b1; c.comparator_mode = CMP_LTU; end
          3'b100: begin c.use_alu = 1'b1; c.alu_mode = ALU_XOR; end
          3'b110: begin c.use_alu = 1'b1; c.alu_mode = ALU_OR; end
          3'b111: begin c.use_alu = 1'b1; c.alu_mode = ALU_AND; end
          3'b001: begin
            c.use_shifter  = 1'b1;
            c.shifter_mode = SH_LSL;
            ill            = (f7 != 7'b0000000);
          end
          default: begin
            c.use_shifter  = 1'b1;
            c.shifter_mode = f7[5] ? SH_ASR : SH_LSR;
            ill            = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      7'b0000011: begin
        c.use_alu         = 1'b1;
        c.alu_mode        = ALU_ADD;
        c.alu_src2        = 1'b1;
        c.imm             = imm_i;
        c.mem_read_en     = 1'b1;
        c.reg_write_en    = 1'b1;
        c.mem_access_mode = f3[1:0];
        c.mem_read_signed = !f3[2];
        ill               = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        c.use_alu         = 1'b1;
        c.alu_mode        = ALU_ADD;
        c.alu_src2        = 1'b1;
        c.imm             = imm_s;
        c.mem_write_en    = 1'b1;
        c.mem_access_mode = f3[1:0];
        ill               = (f3 >= 3'b011);
      end
      7'b0110111, 7'b0010111: begin
        c.use_alu      = 1'b1;
        c.alu_mode     = opc[5] ? ALU_PASS : ALU_ADD;
        c.alu_src1     = !opc[5];
        c.alu_src2     = 1'b1;
        c.imm          = imm_u;
        c.reg_write_en = 1'b1;
      end
      7'b1101111, 7'b1100111: begin
        c.use_alu      = 1'b1;
        c.alu_mode     = ALU_ADD;
        c.alu_src1     = 1'b1;
        c.alu_src2     = 1'b1;
        c.imm          = 32'd4;
        c.reg_write_en = 1'b1;
        c.is_bj        = 1'b1;
        c.is_jalr      = !opc[3];
        c.target       = opc[3] ? imm_j : imm_i;
        ill            = !opc[3] && (f3 != 3'b000);
      end
      7'b1100011: begin
        c.use_comparator = 1'b1;
        c.is_bj          = 1'b1;
        c.imm            = imm_b;
        c.target         = imm_b;
        case (f3)
          3'b000:  c.comparator_mode = CMP_EQ;
          3'b001:  c.comparator_mode = CMP_NEQ;
          3'b100:  c.comparator_mode = CMP_LT;
          3'b101:  c.comparator_mode = CMP_GE;
          3'b110:  c.comparator_mode = CMP_LTU;
          3'b111:  c.comparator_mode = CMP_GEU;
          default: ill = 1'b1;
        endcase
      end
      7'b0001111: ;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c         = ctrl_idle();
      c.rd      = ins[11:7];
      c.rs1     = ins[19:15];
      c.rs2     = ins[24:20];
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  logic [31:0]   instr_mem_q [QUEUE_DEPTH];
  logic [31:0]   pc_mem_q    [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_pc_q;
  ctrl_t         ctrl_q;
  logic          push, pop;

  assign bus.in_ready = (count_q != CW'(QUEUE_DEPTH));

  // Next-state for queue pointers, occupancy and output valid; flush wins.
  always_comb begin
    push        = bus.in_valid && bus.in_ready && !flush;
    pop         = (count_q != '0) && (!out_valid_q || bus.out_ready) && !flush;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    out_valid_d = pop ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  // Queue storage: plain data, written on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.in_instr;
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
    end
  end

  // Control state: pointers, occupancy and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Output bundle: decode the queue head whenever it is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= ctrl_idle();
      out_pc_q <= '0;
    end else if (pop) begin
      ctrl_q   <= decode(instr_mem_q[rd_ptr_q]);
      out_pc_q <= pc_mem_q[rd_ptr_q];
    end
  end

  assign queue_count         = count_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_pc          = out_pc_q;
  assign bus.rd_addr         = ctrl_q.rd;
  assign bus.rs1_addr        = ctrl_q.rs1;
  assign bus.rs2_addr        = ctrl_q.rs2;
  assign bus.imm_value       = ctrl_q.imm;
  assign bus.target_imm      = ctrl_q.target;
  assign bus.use_alu         = ctrl_q.use_alu;
  assign bus.use_shifter     = ctrl_q.use_shifter;
  assign bus.use_comparator  = ctrl_q.use_comparator;
  assign bus.use_muldiv      = ctrl_q.use_muldiv;
  assign bus.alu_src1        = ctrl_q.alu_src1;
  assign bus.alu_src2        = ctrl_q.alu_src2;
  assign bus.alu_mode        = ctrl_q.alu_mode;
  assign bus.shifter_mode    = ctrl_q.shifter_mode;
  assign bus.comparator_mode = ctrl_q.comparator_mode;
  assign bus.muldiv_mode     = ctrl_q.muldiv_mode;
  assign bus.reg_write_en    = ctrl_q.reg_write_en;
  assign bus.mem_read_en     = ctrl_q.mem_read_en;
  assign bus.mem_write_en    = ctrl_q.mem_write_en;
  assign bus.mem_access_mode = ctrl_q.mem_access_mode;
  assign bus.mem_read_signed = ctrl_q.mem_read_signed;
  assign bus.is_bj           = ctrl_q.is_bj;
  assign bus.is_jalr         = ctrl_q.is_jalr;
  assign bus.illegal         = ctrl_q.illegal;
endmodule
